irq_pending_4ch: RTL and testbench
==================================

# irq_pending_4ch

Four-channel interrupt request capture stage that sits directly upstream of the 4-to-2 priority encoder. It synchronises four raw request lines, detects rising edges, and latches them into pending bits. It then presents the masked pending vector to the encoder's `i[3:0]` input. The encoder's `y[1:0]` is fed back as `ack_id`, so an acknowledge clears exactly the channel that was granted.

## Interface
- `SYNC_STAGES`, default 2: number of synchroniser flops per request line; legal values 2 or 3.

Ports (clock and reset first):
- `clk`  in  1  rising-edge clock; one clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `req`  in  4  raw request lines, asynchronous to `clk`; bit 3 is highest priority downstream.
- `mask_wr`  in  1  load `mask` from `mask_din` this cycle.
- `mask_din`  in  4  new mask value; 1 = channel masked.
- `ack`  in  1  acknowledge strobe for channel `ack_id`.
- `ack_id`  in  2  channel being acknowledged (encoder `y`).
- `ovf_clr`  in  1  clear all `overflow` bits.
- `pend`  out  4  `pend_q & ~mask`; drives encoder `i[3:0]`.
- `irq`  out  1  OR of `pend` (equals encoder `v`).
- `mask`  out  4  current mask register.
- `overflow`  out  4  sticky per-channel lost-event flags.

## Operation
- Synchroniser: `req[n]` passes through `SYNC_STAGES` flops. Edge detect: `rise[n] = s_last[n] & ~s_prev[n]`, using the last synchroniser stage and one extra history flop.
- Pending register `pend_q[3:0]`, per bit:
  - Set when `rise[n]`.
  - Cleared when `ack && ack_id==n && !rise[n]`.
  - If set and clear occur in the same cycle, set wins; the bit stays 1 and is not counted as overflow.
  - Otherwise the bit holds.
- Ack of a channel whose `pend_q` bit is 0 is ignored with no side effect. Ack of a masked but pending channel clears it.
- Mask: loaded on `mask_wr`. Masked channels still latch into `pend_q`, but are hidden from `pend` and `irq`. Unmasking exposes any held bit on the next cycle.
- Overflow: `overflow[n]` is set when `rise[n]` occurs while `pend_q[n]` is already 1 and that bit is not being acked that cycle. `ovf_clr` clears all bits. If `ovf_clr` and a new overflow occur in the same cycle, the set wins.
- `pend`, `irq` and `mask` are combinational from registers only; there is no input-to-output combinational path.

## Timing
- Reset (synchronous, `rst`=1 at an edge):
  - Synchroniser and history flops go to 0, `pend_q`=0, `mask`=0, `overflow`=0.
  - Outputs therefore read `pend`=0, `irq`=0, `mask`=0, `overflow`=0 from the edge after reset is sampled.
- A `req` line held high across reset release is treated as a rising edge and becomes pending after the normal latency.
- Reset mid-operation discards all pending and overflow state, including edges still in flight in the synchroniser.
- Latency: `req` going high before edge E0 makes `pend[n]` and `irq` high after edge E0+`SYNC_STAGES`. With the default, that is 3 edges (E0, E1, E2).
- `ack` sampled at edge E: the bit drops after E, and the encoder sees the next-priority channel in the same cycle.
- `mask_wr` at edge E: the new mask affects `pend`/`irq` after E.
- A `req` pulse shorter than one `clk` period may be missed. Software-visible requests must be held at least 2 clock periods.

## Configuration
- Macro `IRQ_PEND_OVF_EN`.
- Defined: overflow flags behave as described.
- Undefined:
  - No overflow flops are built; `overflow` is tied to 4'b0000.
  - `ovf_clr` is ignored.
  - All other behaviour is unchanged.

## Test plan
- Reset, then `req`=4'b0100 held → `pend`=4'b0100 and `irq`=1 exactly 3 edges after `req` rises; `overflow`=0.
- `req` rises 4'b1010 together, then `ack` with `ack_id`=3 → `pend` goes 4'b1010 → 4'b0010. Then `ack_id`=1 → `pend`=0, `irq`=0.
- `mask_din`=4'b0001 with `mask_wr`, then pulse `req[0]` → `pend`=0 and `irq`=0 while `pend_q[0]` is held. Writing mask 0 → `pend`=4'b0001 the next cycle.
- Second rising edge on `req[2]` while pending and unacked → `overflow`=4'b0100 (macro defined) or 4'b0000 (undefined). `ovf_clr` → 4'b0000.
- `ack`/`ack_id`=1 in the same cycle as a new `rise[1]` → `pend[1]` stays 1 and `overflow[1]` stays 0. Ack of non-pending `ack_id`=0 → no change.
- Assert `rst` for 1 cycle with `pend`=4'b1111 and an edge in the synchroniser → all outputs 0 after the reset edge. The in-flight edge does not reappear unless `req` is still high.

Source files
------------

// File: rtl/irq_pending_4ch.sv
// Four-channel interrupt capture: synchronise, detect rising edges, latch pending
// bits, mask them for the priority encoder. Macro IRQ_PEND_OVF_EN enables overflow flags.
module irq_pending_4ch #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       mask_wr,
    input  logic [3:0] mask_din,
    input  logic       ack,
    input  logic [1:0] ack_id,
    input  logic       ovf_clr,
    output logic [3:0] pend,
    output logic       irq,
    output logic [3:0] mask,
    output logic [3:0] overflow
);

    logic [SYNC_STAGES-1:0][3:0] sync_q;
    logic [3:0]                  hist_q;
    logic [3:0]                  rise;
    logic [3:0]                  ack_hit;
    logic [3:0]                  pend_q;
    logic [3:0]                  pend_d;
    logic [3:0]                  mask_q;
    logic [3:0]                  mask_d;

    // History resets to 0, so a line held high through reset release reads as an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], req};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_chan
            assign ack_hit[gi] = ack && (ack_id == 2'(gi));
            // A fresh edge outranks an acknowledge in the same cycle.
            assign pend_d[gi]  = rise[gi] | (pend_q[gi] & ~ack_hit[gi]);
        end
    endgenerate

    assign mask_d = mask_wr ? mask_din : mask_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
            mask_q <= '0;
        end else begin
            pend_q <= pend_d;
            mask_q <= mask_d;
        end
    end

`ifdef IRQ_PEND_OVF_EN
    logic [3:0] ovf_q;
    logic [3:0] ovf_d;
    logic [3:0] ovf_set;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_ovf
            assign ovf_set[gi] = rise[gi] & pend_q[gi] & ~ack_hit[gi];
            assign ovf_d[gi]   = ovf_set[gi] | (ovf_q[gi] & ~ovf_clr);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow = ovf_q;
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;
    assign overflow       = 4'b0000;
`endif

    assign pend = pend_q & ~mask_q;
    assign irq  = |pend;
    assign mask = mask_q;

endmodule

// File: tb/tb_irq_pending_4ch.sv
// Randomised and directed bench for irq_pending_4ch against a cycle-level model
// built from the request history seen since the last reset.
module tb_irq_pending_4ch;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       mask_wr;
    logic [3:0] mask_din;
    logic       ack;
    logic [1:0] ack_id;
    logic       ovf_clr;
    logic [3:0] pend;
    logic       irq;
    logic [3:0] mask;
    logic [3:0] overflow;

    irq_pending_4ch #(.SYNC_STAGES(S)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .mask_wr  (mask_wr),
        .mask_din (mask_din),
        .ack      (ack),
        .ack_id   (ack_id),
        .ovf_clr  (ovf_clr),
        .pend     (pend),
        .irq      (irq),
        .mask     (mask),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int vectors   = 0;
    int miscomp   = 0;
    int cyc       = 0;

    // Model state: req as sampled at each edge since reset, newest first.
    logic [3:0] seen[$];
    logic [3:0] m_pend, m_mask, m_ovf;

    function automatic void check(string name, logic [3:0] act, logic [3:0] exp);
        vectors++;
        if (act !== exp) begin
            miscomp++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endfunction

    task automatic model_reset();
        seen.delete();
        for (int i = 0; i <= S; i++) seen.push_front(4'b0000);
        m_pend = '0;
        m_mask = '0;
        m_ovf  = '0;
    endtask

    // One clock: advance model with the inputs the DUT sees, then compare.
    task automatic step();
        logic [3:0] edge_v, acked, lost;
        @(posedge clk);
        cyc++;
        if (rst) begin
            model_reset();
        end else begin
            // The request seen S edges ago, compared with the one before it.
            edge_v = seen[S-1] & ~seen[S];
            acked  = ack ? (4'b0001 << ack_id) : 4'b0000;
            lost   = edge_v & m_pend & ~acked;
            m_pend = edge_v | (m_pend & ~acked);
`ifdef IRQ_PEND_OVF_EN
            m_ovf  = lost | (ovf_clr ? 4'b0000 : m_ovf);
`else
            m_ovf  = 4'b0000;
`endif
            if (mask_wr) m_mask = mask_din;
            seen.push_front(req);
            void'(seen.pop_back());
        end
        #1;
        check("pend", pend, m_pend & ~m_mask);
        check("irq", {3'b000, irq}, {3'b000, |(m_pend & ~m_mask)});
        check("mask", mask, m_mask);
        check("overflow", overflow, m_ovf);
        mask_wr = 1'b0;
        ack     = 1'b0;
        ovf_clr = 1'b0;
    endtask

    task automatic steps(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    logic [3:0] ovf_exp;

    initial begin
        rst = 1'b1; req = '0; mask_wr = 1'b0; mask_din = '0;
        ack = 1'b0; ack_id = '0; ovf_clr = 1'b0;
        model_reset();
        #2;
        steps(2);
        check("lit_reset_pend", pend, 4'b0000);
        check("lit_reset_ovf", overflow, 4'b0000);
        rst = 1'b0;
        steps(2);

        // Latency: high before E0, visible after E2.
        req = 4'b0100;
        steps(2);
        check("lit_lat_early", pend, 4'b0000);
        step();
        check("lit_lat_pend", pend, 4'b0100);
        check("lit_lat_irq", {3'b000, irq}, 4'b0001);
        ack = 1'b1; ack_id = 2'd2; step();

        // Simultaneous rise on 3 and 1, acked in priority order.
        req = 4'b1110;
        steps(3);
        check("lit_1010", pend, 4'b1010);
        ack = 1'b1; ack_id = 2'd3; step();
        check("lit_ack3", pend, 4'b0010);
        ack = 1'b1; ack_id = 2'd1; step();
        check("lit_ack1", pend, 4'b0000);
        check("lit_ack1_irq", {3'b000, irq}, 4'b0000);

        // Masked channel latches but stays hidden until unmasked.
        mask_wr = 1'b1; mask_din = 4'b0001; step();
        req = 4'b1111; steps(2);
        req = 4'b1110; steps(3);
        check("lit_masked", pend, 4'b0000);
        check("lit_mask", mask, 4'b0001);
        mask_wr = 1'b1; mask_din = 4'b0000; step();
        check("lit_unmask", pend, 4'b0001);

        // Second edge on channel 2 while still pending.
        req = 4'b1010; steps(2);
        req = 4'b1110; steps(3);
        req = 4'b1010; steps(2);
        req = 4'b1110; steps(3);
`ifdef IRQ_PEND_OVF_EN
        ovf_exp = 4'b0100;
`else
        ovf_exp = 4'b0000;
`endif
        check("lit_ovf", overflow, ovf_exp);
        ovf_clr = 1'b1; step();
        check("lit_ovf_clr", overflow, 4'b0000);

        // Channel 1: make pending, then ack it in the same cycle as a new edge.
        req = 4'b1100; steps(2);
        req = 4'b1110; steps(3);
        req = 4'b1100; steps(2);
        req = 4'b1110; steps(2);
        ack = 1'b1; ack_id = 2'd1; step();
        check("lit_setwins", pend & 4'b0010, 4'b0010);
        check("lit_setwins_ovf", overflow & 4'b0010, 4'b0000);
        ack = 1'b1; ack_id = 2'd0; step();
        ack = 1'b1; ack_id = 2'd0; step();
        check("lit_ack_idle", pend & 4'b0001, 4'b0000);

        // Reset with everything pending and an edge in flight.
        req = 4'b0000; steps(3);
        req = 4'b1111; steps(3);
        check("lit_all", pend, 4'b1111);
        req = 4'b0000; steps(2);
        req = 4'b1111; step();
        rst = 1'b1; req = 4'b0000; step();
        check("lit_rst_pend", pend, 4'b0000);
        check("lit_rst_irq", {3'b000, irq}, 4'b0000);
        rst = 1'b0; steps(4);
        check("lit_rst_noghost", pend, 4'b0000);

        // Random phase.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                mask_wr = 1'b1; mask_din = 4'($urandom);
            end
            if ($urandom_range(0, 2) == 0) begin
                ack = 1'b1; ack_id = 2'($urandom);
            end
            ovf_clr = ($urandom_range(0, 15) == 0);
            rst     = ($urandom_range(0, 199) == 0);
            step();
            rst = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscomp);
        $finish;
    end

endmodule
